// File: rtl/csr_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_pwm_pkg
//  Description : Shared constants for the CSR/PWM controller: SPI command
//                opcodes, register address map, CTRL bit positions and the
//                byte-parser state type.
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
package csr_pwm_pkg;

  // Command byte is {op[1:0], addr}
  localparam logic [1:0] OP_WR = 2'b10;
  localparam logic [1:0] OP_RD = 2'b01;

  // Global register addresses
  localparam int ADDR_CTRL      = 0;
  localparam int ADDR_PRESCALE  = 1;
  localparam int ADDR_GPIO_OUT  = 2;
  localparam int ADDR_PWM_ROUTE = 3;

  // Channel c occupies ADDR_CH_BASE + CH_STRIDE*c .. +3
  // (PERIOD_H, PERIOD_L, DUTY_H, DUTY_L)
  localparam int ADDR_CH_BASE = 4;
  localparam int CH_STRIDE    = 4;

  // CTRL bit positions
  localparam int CTRL_SOFT_RST = 0;
  localparam int CTRL_PWM_EN   = 1;
  localparam int CTRL_GPIO_EN  = 2;

  // Byte parser states
  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_WR_DATA = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/csr_pwm_ctrl_pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_channel
//  Description : One PWM channel: PERIOD/DUTY registers, period counter and
//                duty compare. With CSR_PWM_SHADOW_EN defined, writes land in
//                shadow registers copied to the active set on counter wrap
//                (or continuously while PWM is disabled).
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
module pwm_channel
  import csr_pwm_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      pwm_en,
  input  logic                      tick,
  input  logic                      wr_en,
  input  logic [1:0]                wr_sel,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic [2*DATA_WIDTH-1:0]   period_rd,
  output logic [2*DATA_WIDTH-1:0]   duty_rd,
  output logic                      pwm_d
);

  localparam int PW = 2 * DATA_WIDTH;

  // Software-visible copies (these are the shadows in the shadowed build)
  logic [PW-1:0] period_q, period_d;
  logic [PW-1:0] duty_q, duty_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] w_period_act;
  logic [PW-1:0] w_duty_act;
  logic          w_wrap;

  assign period_rd = period_q;
  assign duty_rd   = duty_q;

  // Byte-wise update of the written PERIOD/DUTY halves
  always_comb begin
    period_d = period_q;
    duty_d   = duty_q;
    if (wr_en) begin
      case (wr_sel)
        2'd0: period_d[PW-1:DATA_WIDTH] = wr_data;
        2'd1: period_d[DATA_WIDTH-1:0]  = wr_data;
        2'd2: duty_d[PW-1:DATA_WIDTH]   = wr_data;
        2'd3: duty_d[DATA_WIDTH-1:0]    = wr_data;
      endcase
    end
  end

`ifdef CSR_PWM_SHADOW_EN
  logic [PW-1:0] act_period_q, act_period_d;
  logic [PW-1:0] act_duty_q, act_duty_d;
  logic          w_load;

  assign w_period_act = act_period_q;
  assign w_duty_act   = act_duty_q;
  assign w_load       = !pwm_en || (tick && w_wrap);

  // Active set follows the shadows only at period boundaries
  always_comb begin
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    if (w_load) begin
      act_period_d = period_q;
      act_duty_d   = duty_q;
    end
  end

  // Active register set
  always_ff @(posedge clk) begin
    if (clr) begin
      act_period_q <= '0;
      act_duty_q   <= '0;
    end else begin
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
    end
  end
`else
  assign w_period_act = period_q;
  assign w_duty_act   = duty_q;
`endif

  // >= rather than == so a PERIOD lowered below cnt wraps on the next tick
  assign w_wrap = (cnt_q >= w_period_act);

  // Period counter advances on prescaler tick, held at 0 while disabled
  always_comb begin
    cnt_d = cnt_q;
    if (!pwm_en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = w_wrap ? '0 : cnt_q + PW'(1);
    end
  end

  assign pwm_d = pwm_en & (cnt_q < w_duty_act);

  // Channel state registers
  always_ff @(posedge clk) begin
    if (clr) begin
      period_q <= '0;
      duty_q   <= '0;
      cnt_q    <= '0;
    end else begin
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/csr_pwm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : csr_pwm_ctrl
//  Description : SPI byte-driven CSR bank with NUM_CH PWM channels, shared
//                prescaler and GPIO port with per-bit PWM routing.
//                Optional macro CSR_PWM_SHADOW_EN: shadowed PERIOD/DUTY.
//  Revision    : 1.0  initial multi-channel release
// ============================================================================
module csr_pwm_ctrl
  import csr_pwm_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_rdy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_latch,
  output logic                  soft_rst,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic [DATA_WIDTH-1:0] gpio_out
);

  localparam int PW     = 2 * DATA_WIDTH;
  localparam int CH_END = ADDR_CH_BASE + CH_STRIDE * NUM_CH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_latch_q, data_latch_d;
  logic                  soft_rst_q;
  logic                  pwm_en_q, pwm_en_d;
  logic                  gpio_en_q, gpio_en_d;
  logic [DATA_WIDTH-1:0] prescale_q, prescale_d;
  logic [DATA_WIDTH-1:0] gpio_reg_q, gpio_reg_d;
  logic [DATA_WIDTH-1:0] route_q, route_d;
  logic [DATA_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [NUM_CH-1:0]     pwm_out_q, pwm_out_d;
  logic [DATA_WIDTH-1:0] gpio_out_q, gpio_out_d;

  logic [1:0]            w_cmd_op;
  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic                  w_wr_en;
  logic                  w_soft;
  logic                  w_clr;
  logic                  w_tick;
  logic [ADDR_WIDTH-1:0] w_wr_off, w_rd_off;
  logic                  w_wr_ch_hit, w_rd_ch_hit;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic [PW-1:0]         w_period_rd [NUM_CH];
  logic [PW-1:0]         w_duty_rd   [NUM_CH];

  assign w_cmd_op   = data_in[DATA_WIDTH-1:DATA_WIDTH-2];
  assign w_cmd_addr = data_in[ADDR_WIDTH-1:0];
  assign w_wr_en    = data_rdy && (state_q == ST_WR_DATA);
  // Soft reset clears everything on the same edge the CTRL write lands
  assign w_soft     = w_wr_en && (addr_q == ADDR_WIDTH'(ADDR_CTRL)) && data_in[CTRL_SOFT_RST];
  assign w_clr      = rst || w_soft;

  assign w_wr_off    = addr_q - ADDR_WIDTH'(ADDR_CH_BASE);
  assign w_rd_off    = w_cmd_addr - ADDR_WIDTH'(ADDR_CH_BASE);
  assign w_wr_ch_hit = (addr_q >= ADDR_WIDTH'(ADDR_CH_BASE)) && (int'(addr_q) < CH_END);
  assign w_rd_ch_hit = (w_cmd_addr >= ADDR_WIDTH'(ADDR_CH_BASE)) && (int'(w_cmd_addr) < CH_END);

  // Byte parser: command in IDLE, data byte in WR_DATA, read response
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    data_latch_d = 1'b0;
    if (data_rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (w_cmd_op == OP_WR) begin
            addr_d  = w_cmd_addr;
            state_d = ST_WR_DATA;
          end else if (w_cmd_op == OP_RD) begin
            data_out_d   = w_rd_data;
            data_latch_d = 1'b1;
          end
        end
        ST_WR_DATA: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Read mux; unmapped addresses return 0, SOFT_RST always reads 0
  always_comb begin
    w_rd_data = '0;
    if (w_rd_ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_rd_off[ADDR_WIDTH-1:2] == (ADDR_WIDTH-2)'(c)) begin
          case (w_rd_off[1:0])
            2'd0: w_rd_data = w_period_rd[c][PW-1:DATA_WIDTH];
            2'd1: w_rd_data = w_period_rd[c][DATA_WIDTH-1:0];
            2'd2: w_rd_data = w_duty_rd[c][PW-1:DATA_WIDTH];
            2'd3: w_rd_data = w_duty_rd[c][DATA_WIDTH-1:0];
          endcase
        end
      end
    end else begin
      case (w_cmd_addr)
        ADDR_WIDTH'(ADDR_CTRL): begin
          w_rd_data[CTRL_PWM_EN]  = pwm_en_q;
          w_rd_data[CTRL_GPIO_EN] = gpio_en_q;
        end
        ADDR_WIDTH'(ADDR_PRESCALE):  w_rd_data = prescale_q;
        ADDR_WIDTH'(ADDR_GPIO_OUT):  w_rd_data = gpio_reg_q;
        ADDR_WIDTH'(ADDR_PWM_ROUTE): w_rd_data = route_q;
        default:                     w_rd_data = '0;
      endcase
    end
  end

  // Global CSR writes
  always_comb begin
    pwm_en_d   = pwm_en_q;
    gpio_en_d  = gpio_en_q;
    prescale_d = prescale_q;
    gpio_reg_d = gpio_reg_q;
    route_d    = route_q;
    if (w_wr_en) begin
      case (addr_q)
        ADDR_WIDTH'(ADDR_CTRL): begin
          pwm_en_d  = data_in[CTRL_PWM_EN];
          gpio_en_d = data_in[CTRL_GPIO_EN];
        end
        ADDR_WIDTH'(ADDR_PRESCALE):  prescale_d = data_in;
        ADDR_WIDTH'(ADDR_GPIO_OUT):  gpio_reg_d = data_in;
        ADDR_WIDTH'(ADDR_PWM_ROUTE): route_d    = data_in;
        default: ;
      endcase
    end
  end

  // Prescaler; >= lets a PRESCALE lowered below the count wrap promptly
  assign w_tick = pwm_en_q && (pre_cnt_q >= prescale_q);

  always_comb begin
    pre_cnt_d = pre_cnt_q + DATA_WIDTH'(1);
    if (!pwm_en_q || w_tick) begin
      pre_cnt_d = '0;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_ch_wr;
    assign w_ch_wr = w_wr_en && w_wr_ch_hit &&
                     (w_wr_off[ADDR_WIDTH-1:2] == (ADDR_WIDTH-2)'(c));
    pwm_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
      .clk       (clk),
      .clr       (w_clr),
      .pwm_en    (pwm_en_q),
      .tick      (w_tick),
      .wr_en     (w_ch_wr),
      .wr_sel    (w_wr_off[1:0]),
      .wr_data   (data_in),
      .period_rd (w_period_rd[c]),
      .duty_rd   (w_duty_rd[c]),
      .pwm_d     (pwm_out_d[c])
    );
  end

  // GPIO bits below NUM_CH may be routed from the matching PWM channel
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_gpio
    if (i < NUM_CH) begin : g_routed
      assign gpio_out_d[i] = gpio_en_q & (route_q[i] ? pwm_out_d[i] : gpio_reg_q[i]);
    end else begin : g_direct
      assign gpio_out_d[i] = gpio_en_q & gpio_reg_q[i];
    end
  end

  // All state and registered outputs; soft reset pulse survives its own clear
  always_ff @(posedge clk) begin
    if (rst) begin
      soft_rst_q <= 1'b0;
    end else begin
      soft_rst_q <= w_soft;
    end
    if (w_clr) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      data_out_q   <= '0;
      data_latch_q <= 1'b0;
      pwm_en_q     <= 1'b0;
      gpio_en_q    <= 1'b0;
      prescale_q   <= '0;
      gpio_reg_q   <= '0;
      route_q      <= '0;
      pre_cnt_q    <= '0;
      pwm_out_q    <= '0;
      gpio_out_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
      data_latch_q <= data_latch_d;
      pwm_en_q     <= pwm_en_d;
      gpio_en_q    <= gpio_en_d;
      prescale_q   <= prescale_d;
      gpio_reg_q   <= gpio_reg_d;
      route_q      <= route_d;
      pre_cnt_q    <= pre_cnt_d;
      pwm_out_q    <= pwm_out_d;
      gpio_out_q   <= gpio_out_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_latch = data_latch_q;
  assign soft_rst   = soft_rst_q;
  assign pwm_out    = pwm_out_q;
  assign gpio_out   = gpio_out_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_pwm_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_csr_pwm_ctrl
//  Description : Scoreboard bench for csr_pwm_ctrl. Reads push expected bytes
//                with a due cycle; pin expectations are posted per cycle. A
//                negedge monitor pops and compares.
//  Revision    : 1.0
// ============================================================================
module tb_csr_pwm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_rdy;
  logic [7:0] data_out;
  logic       data_latch;
  logic       soft_rst;
  logic [3:0] pwm_out;
  logic [7:0] gpio_out;

  always #5 clk = ~clk;

  csr_pwm_ctrl #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .NUM_CH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_rdy   (data_rdy),
    .data_out   (data_out),
    .data_latch (data_latch),
    .soft_rst   (soft_rst),
    .pwm_out    (pwm_out),
    .gpio_out   (gpio_out)
  );

  typedef struct {
    logic [7:0] data;
    int         due;
  } rd_exp_t;

  rd_exp_t    rd_q[$];
  rd_exp_t    mon_e;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         pin_req = 0;
  int         pin_ack = 0;
  string      pc_name;
  logic [3:0] pc_pwm_mask, pc_pwm;
  logic       pc_gpio_chk, pc_soft_chk, pc_soft;
  logic [7:0] pc_gpio;
  logic       end_req = 1'b0;
  logic       end_done = 1'b0;

  // Monitor: read scoreboard, pin expectations, final drain check
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (data_latch === 1'b1) begin
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL read_unexpected: data_latch=1 data_out=%02h at cycle %0d, none pending", data_out, cyc);
      end else begin
        mon_e = rd_q.pop_front();
        if (data_out !== mon_e.data || mon_e.due != cyc) begin
          n_fail++;
          $display("FAIL read_data: got %02h at cycle %0d, expected %02h at cycle %0d",
                   data_out, cyc, mon_e.data, mon_e.due);
        end
      end
    end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
      n_tests++;
      n_fail++;
      mon_e = rd_q.pop_front();
      $display("FAIL read_latch: no data_latch at cycle %0d, expected %02h", cyc, mon_e.data);
    end
    if (pin_req != pin_ack) begin
      pin_ack = pin_req;
      if (pc_pwm_mask != 4'h0) begin
        n_tests++;
        if ((pwm_out & pc_pwm_mask) !== (pc_pwm & pc_pwm_mask)) begin
          n_fail++;
          $display("FAIL %s pwm_out: got %h expected %h (mask %h) cycle %0d",
                   pc_name, pwm_out, pc_pwm, pc_pwm_mask, cyc);
        end
      end
      if (pc_gpio_chk) begin
        n_tests++;
        if (gpio_out !== pc_gpio) begin
          n_fail++;
          $display("FAIL %s gpio_out: got %02h expected %02h cycle %0d", pc_name, gpio_out, pc_gpio, cyc);
        end
      end
      if (pc_soft_chk) begin
        n_tests++;
        if (soft_rst !== pc_soft) begin
          n_fail++;
          $display("FAIL %s soft_rst: got %b expected %b cycle %0d", pc_name, soft_rst, pc_soft, cyc);
        end
      end
    end
    if (end_req && !end_done) begin
      end_done = 1'b1;
      n_tests++;
      if (rd_q.size() != 0) begin
        n_fail++;
        $display("FAIL read_drain: %0d reads never answered", rd_q.size());
      end
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    data_in  = b;
    data_rdy = 1'b1;
    cyc1();
    data_rdy = 1'b0;
    data_in  = 8'h00;
  endtask

  task automatic wr(input int a, input logic [7:0] v);
    send({2'b10, 6'(a)});
    send(v);
  endtask

  task automatic rd(input int a, input logic [7:0] exp_v);
    rd_exp_t e;
    send({2'b01, 6'(a)});
    e.data = exp_v;
    e.due  = cyc + 1;
    rd_q.push_back(e);
  endtask

  // Expectation applies to the next negedge
  task automatic expect_pins(input string name, input logic [3:0] pm, input logic [3:0] pv,
                             input logic gc, input logic [7:0] gv,
                             input logic sc, input logic sv);
    pc_name     = name;
    pc_pwm_mask = pm;
    pc_pwm      = pv;
    pc_gpio_chk = gc;
    pc_gpio     = gv;
    pc_soft_chk = sc;
    pc_soft     = sv;
    pin_req     = pin_req + 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int m_eff;
    logic e_bit;
    rst      = 1'b1;
    data_rdy = 1'b0;
    data_in  = 8'h00;
    repeat (3) cyc1();
    rst = 1'b0;
    expect_pins("reset", 4'hF, 4'h0, 1'b1, 8'h00, 1'b1, 1'b0);
    cyc1();

    // Reset values of the whole map, back-to-back reads
    for (int a = 0; a < 20; a++) rd(a, 8'h00);

    // GPIO direct drive
    wr(2, 8'hA5);
    wr(0, 8'h04);
    cyc1();
    expect_pins("gpio_direct", 4'h0, 4'h0, 1'b1, 8'hA5, 1'b1, 1'b0);
    cyc1();
    rd(2, 8'hA5);
    rd(0, 8'h04);

    // Ch0 PERIOD=9 DUTY=3 PRESCALE=0: 10-cycle period, 3 high
    wr(1, 8'h00);
    wr(5, 8'h09);
    wr(7, 8'h03);
    wr(0, 8'h02);
    for (int j = 0; j < 25; j++) begin
      e_bit = (j == 0) ? 1'b0 : (((j - 1) % 10) < 3);
      expect_pins("pwm_ch0", 4'h1, {3'b000, e_bit}, (j == 2), 8'h00, 1'b0, 1'b0);
      cyc1();
    end

    // Ch1 DUTY > PERIOD -> constant high
    wr(1, 8'h01);
    wr(9, 8'h03);
    wr(11, 8'h05);
    repeat (12) cyc1();
    for (int j = 0; j < 8; j++) begin
      expect_pins("pwm_ch1_high", 4'h2, 4'h2, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc1();
    end
    rd(11, 8'h05);

    // Route ch1 onto gpio bit1
    wr(3, 8'h02);
    wr(0, 8'h06);
    cyc1();
    cyc1();
    for (int j = 0; j < 4; j++) begin
      expect_pins("gpio_route", 4'h2, 4'h2, 1'b1, 8'hA7, 1'b0, 1'b0);
      cyc1();
    end

    // Ch1 DUTY=0 -> constant low
    wr(11, 8'h00);
    repeat (12) cyc1();
    for (int j = 0; j < 8; j++) begin
      expect_pins("pwm_ch1_low", 4'h2, 4'h0, 1'b1, 8'hA5, 1'b0, 1'b0);
      cyc1();
    end

    // Hard reset, then duty change 3->7 mid-period on ch0
    rst = 1'b1;
    cyc1();
    cyc1();
    rst = 1'b0;
    expect_pins("reset2", 4'hF, 4'h0, 1'b1, 8'h00, 1'b1, 1'b0);
    cyc1();
    rd(2, 8'h00);
    wr(5, 8'h09);
    wr(7, 8'h03);
    wr(0, 8'h02);
`ifdef CSR_PWM_SHADOW_EN
    m_eff = 10;
`else
    m_eff = 5;
`endif
    for (int k = 1; k <= 30; k++) begin
      int j;
      j = k - 1;
      if (k == 4) begin
        data_in = 8'h87; data_rdy = 1'b1;
      end else if (k == 5) begin
        data_in = 8'h07; data_rdy = 1'b1;
      end else begin
        data_in = 8'h00; data_rdy = 1'b0;
      end
      e_bit = (j == 0) ? 1'b0 : (((j - 1) % 10) < (((j - 1) >= m_eff) ? 7 : 3));
      expect_pins("pwm_duty_change", 4'h1, {3'b000, e_bit}, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc1();
    end
    data_rdy = 1'b0;
    rd(7, 8'h07);

    // Write command interrupted by rst: next byte must parse as a command
    send(8'h84);
    rst = 1'b1;
    cyc1();
    rst = 1'b0;
    rd(4, 8'h00);
    rd(4, 8'h00);

    // Soft reset clears everything, pulses once
    wr(2, 8'h3C);
    wr(5, 8'h09);
    wr(0, 8'h04);
    cyc1();
    expect_pins("pre_soft", 4'h0, 4'h0, 1'b1, 8'h3C, 1'b1, 1'b0);
    cyc1();
    wr(0, 8'h03);
    expect_pins("soft_pulse", 4'hF, 4'h0, 1'b1, 8'h00, 1'b1, 1'b1);
    cyc1();
    expect_pins("soft_end", 4'hF, 4'h0, 1'b1, 8'h00, 1'b1, 1'b0);
    cyc1();
    rd(0, 8'h00);
    rd(1, 8'h00);
    rd(2, 8'h00);
    rd(5, 8'h00);

    repeat (3) cyc1();
    end_req = 1'b1;
    repeat (2) cyc1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_pwm_ctrl.md
# csr_pwm_ctrl

Parametrised CSR bank with a multi-channel PWM engine and GPIO port, driven byte-wise by the SPI slave block. Replaces the single-channel controller with NUM_CH independent PWM channels, a shared prescaler, explicit command/data framing and GPIO routing of PWM outputs. Sits between the SPI byte interface and the board pins.

## Interface

- ADDR_WIDTH, 6, CSR address width; command byte is {op[1:0], addr}, so ADDR_WIDTH = DATA_WIDTH - 2
- DATA_WIDTH, 8, SPI byte and CSR word width
- NUM_CH, 4, PWM channel count; 1..DATA_WIDTH and 4+4*NUM_CH <= 2**ADDR_WIDTH
- clk  input  1  single clock; all logic on posedge
- rst  input  1  reset, synchronous, active-high
- data_in  input  DATA_WIDTH  byte from SPI block
- data_rdy  input  1  one-cycle strobe, data_in valid
- data_out  output  DATA_WIDTH  read response byte; reset 0
- data_latch  output  1  one-cycle strobe, data_out valid; reset 0
- soft_rst  output  1  one-cycle soft-reset pulse; reset 0
- pwm_out  output  NUM_CH  PWM waveforms; reset 0
- gpio_out  output  DATA_WIDTH  GPIO port; reset 0

## Operation

- Register map (PW = 2*DATA_WIDTH-bit fields split H/L): 0 CTRL {bit0 SOFT_RST, bit1 PWM_EN, bit2 GPIO_EN}; 1 PRESCALE; 2 GPIO_OUT; 3 PWM_ROUTE; channel c at 4+4c: PERIOD_H, PERIOD_L, DUTY_H, DUTY_L. All reset 0.
- Unmapped address: write ignored, read returns 0.
- FSM states: IDLE, WR_DATA. Only bytes with data_rdy=1 are consumed.
- IDLE + byte, op=2'b10: capture addr -> WR_DATA. op=2'b01: read, stay IDLE. op=2'b00/2'b11: ignore.
- WR_DATA + byte: write data_in to captured addr -> IDLE.
- SOFT_RST write with bit0=1: all CSRs, counters, outputs to reset values next edge; soft_rst high exactly that one cycle; bit0 reads back 0.
- Prescaler: counter 0..PRESCALE; tick when equal, then wraps to 0; PRESCALE=0 -> tick every cycle. Runs only while PWM_EN=1.
- Channel counter cnt (PW bits) advances on tick, 0..PERIOD then wraps to 0. PERIOD=0 -> cnt stays 0.
- pwm_out[c] = PWM_EN & (cnt < DUTY), unsigned compare; DUTY=0 -> constant 0; DUTY>PERIOD -> constant 1.
- PWM_EN=0: prescaler and all cnt held at 0, pwm_out=0.
- gpio_out[i] = GPIO_EN & (i<NUM_CH && PWM_ROUTE[i] ? pwm_out[i] : GPIO_OUT[i]).

## Timing

- Read: command byte strobed at edge T -> data_out = CSR[addr] and data_latch=1 during cycle T+1; data_latch deasserts T+2; data_out holds until next read.
- Write: data byte strobed at edge T -> CSR updated at T; new value visible to reads and logic from T+1.
- Byte during data_latch cycle is accepted normally (back-to-back reads allowed, one per cycle).
- All outputs registered; pwm_out and gpio_out change one cycle after the cnt/CSR edge causing them.
- rst anywhere (incl. WR_DATA): FSM to IDLE, pending write dropped, all state to reset values.
- Simultaneous soft reset and tick: soft reset wins.

## Configuration

- CSR_PWM_SHADOW_EN defined: PERIOD/DUTY writes go to shadow registers; active copies load when cnt wraps to 0 (or immediately while PWM_EN=0). Reads return shadow value. Glitch-free duty changes.
- Undefined: writes hit active registers directly; compare uses new value from next cycle.

## Structure

- Package csr_pwm_pkg: op encodings (OP_WR, OP_RD), register address constants, CTRL bit indices, FSM state typedef.
- One sub-module, pwm_channel: cnt, optional shadow regs, compare; instantiated NUM_CH times via generate.

## Test plan

- rst, read addr 0..19 -> every data_out 0, data_latch one cycle each.
- Write GPIO_OUT=0xA5, CTRL=0x04, read back 2 -> gpio_out=0xA5, data_out=0xA5.
- Ch0 PERIOD=9, DUTY=3, PRESCALE=0, CTRL=0x02 -> pwm_out[0] period 10 cycles, high 3.
- PRESCALE=1, ch1 PERIOD=3, DUTY=5 -> pwm_out[1] constant 1; DUTY=0 -> constant 0.
- With CSR_PWM_SHADOW_EN, change ch0 DUTY 3->7 mid-period -> old duty completes, new from next wrap; without macro -> change next cycle.
- Write cmd 0x84, then assert rst before data byte -> no CSR 4 change, next byte parsed as command; CTRL=0x03 -> soft_rst one cycle, all regs 0.
